// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1 TAP FSM with capture/shift/update strobes and glitch-free gated IR/DR clocks
module tap_controller (
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output logic [3:0] state,
  output logic       reset,
  output logic       select,
  output logic       captureDR,
  output logic       shiftDR,
  output logic       updateDR,
  output logic       clockDR,
  output logic       captureIR,
  output logic       shiftIR,
  output logic       updateIR,
  output logic       clockIR,
  output logic       tdo_en
);
  localparam logic [3:0] TLR = 4'hF, RTI = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1;
  localparam logic [3:0] PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9;
  localparam logic [3:0] PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD;
  logic [3:0] r_state, w_next;
  logic       w_sel, w_en_dr, w_en_ir;
  logic       r_select, r_upd_dr, r_upd_ir, r_tdo_en, r_en_dr, r_en_ir;
  always_ff @(posedge tck or negedge trst)
    if (!trst) r_state <= TLR;
    else r_state <= w_next;
  always_comb begin
    w_next = TLR;
    case (r_state)
      TLR:              w_next = tms ? TLR : RTI;
      RTI:              w_next = tms ? SEL_DR : RTI;
      SEL_DR:           w_next = tms ? SEL_IR : CAP_DR;
      CAP_DR, SH_DR:    w_next = tms ? EX1_DR : SH_DR;
      EX1_DR:           w_next = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR:         w_next = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:           w_next = tms ? UPD_DR : SH_DR;
      UPD_DR, UPD_IR:   w_next = tms ? SEL_DR : RTI;
      SEL_IR:           w_next = tms ? TLR : CAP_IR;
      CAP_IR, SH_IR:    w_next = tms ? EX1_IR : SH_IR;
      EX1_IR:           w_next = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR:         w_next = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:           w_next = tms ? UPD_IR : SH_IR;
      default:          w_next = TLR;
    endcase
  end
  always_comb begin
    state     = r_state;
    reset     = r_state != TLR;
    captureDR = r_state == CAP_DR;
    shiftDR   = r_state == SH_DR;
    captureIR = r_state == CAP_IR;
    shiftIR   = r_state == SH_IR;
    w_sel     = (r_state[3] && r_state != TLR && r_state != RTI) || r_state == SEL_IR;
    w_en_dr   = r_state == CAP_DR || r_state == SH_DR;
    w_en_ir   = r_state == CAP_IR || r_state == SH_IR;
  end
  always_ff @(negedge tck or negedge trst)
    if (!trst) begin
      r_select <= 1'b0;
      r_upd_dr <= 1'b0;
      r_upd_ir <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_select <= w_sel;
      r_upd_dr <= r_state == UPD_DR;
      r_upd_ir <= r_state == UPD_IR;
      r_tdo_en <= r_state == SH_DR || r_state == SH_IR;
    end
  // enables are frozen while tck is high so the gated clocks cannot glitch
  always_latch
    if (!trst) begin
      r_en_dr <= 1'b0;
      r_en_ir <= 1'b0;
    end else if (!tck) begin
      r_en_dr <= w_en_dr;
      r_en_ir <= w_en_ir;
    end
  assign select   = r_select;
  assign updateDR = r_upd_dr;
  assign updateIR = r_upd_ir;
  assign tdo_en   = r_tdo_en;
  assign clockDR  = tck & r_en_dr;
  assign clockIR  = tck & r_en_ir;
endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: scoreboard bench for the TAP controller with an attached 32-bit ID register
module tb_tap_controller;
  logic tck = 1'b0, trst = 1'b1, tms = 1'b1;
  logic [3:0] state;
  logic reset, select, captureDR, shiftDR, updateDR, clockDR;
  logic captureIR, shiftIR, updateIR, clockIR, tdo_en;
  int n_chk = 0, n_err = 0;
  int dr_edges = 0, ir_edges = 0;
  int cap_dr_n = 0, upd_dr_n = 0, upd_ir_n = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur = 4'hF;
  localparam logic [31:0] ID = 32'h4BA0_0477;
  logic [31:0] id_sr = '0;
  logic [31:0] id_rd;
  tap_controller dut (
    .tck(tck), .trst(trst), .tms(tms), .state(state), .reset(reset), .select(select),
    .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR), .clockDR(clockDR),
    .captureIR(captureIR), .shiftIR(shiftIR), .updateIR(updateIR), .clockIR(clockIR),
    .tdo_en(tdo_en)
  );
  always #5 tck = ~tck;
  always @(posedge clockDR) begin
    dr_edges++;
    id_sr <= captureDR ? ID : shiftDR ? {1'b0, id_sr[31:1]} : id_sr;
  end
  always @(posedge clockIR) ir_edges++;
  function automatic logic [3:0] nxt(input logic [3:0] s, input logic t);
    case (s)
      4'hF: return t ? 4'hF : 4'hC;
      4'hC: return t ? 4'h7 : 4'hC;
      4'h7: return t ? 4'h4 : 4'h6;
      4'h6, 4'h2: return t ? 4'h1 : 4'h2;
      4'h1: return t ? 4'h5 : 4'h3;
      4'h3: return t ? 4'h0 : 4'h3;
      4'h0: return t ? 4'h5 : 4'h2;
      4'h5, 4'hD: return t ? 4'h7 : 4'hC;
      4'h4: return t ? 4'hF : 4'hE;
      4'hE, 4'hA: return t ? 4'h9 : 4'hA;
      4'h9: return t ? 4'hD : 4'hB;
      4'hB: return t ? 4'h8 : 4'hB;
      4'h8: return t ? 4'hD : 4'hA;
      default: return 4'hF;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic t);
    logic [3:0] e;
    tms = t;
    exp_q.push_back(nxt(cur, t));
    cur = nxt(cur, t);
    @(posedge tck); #1;
    e = exp_q.pop_front();
    chk("state", {28'd0, state}, {28'd0, e});
    chk("reset", reset, e != 4'hF);
    chk("captureDR", captureDR, e == 4'h6);
    chk("shiftDR", shiftDR, e == 4'h2);
    chk("captureIR", captureIR, e == 4'hE);
    chk("shiftIR", shiftIR, e == 4'hA);
    cap_dr_n += int'(captureDR);
    @(negedge tck); #1;
    chk("select", select, e inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD});
    chk("updateDR", updateDR, e == 4'h5);
    chk("updateIR", updateIR, e == 4'hD);
    chk("tdo_en", tdo_en, e == 4'h2 || e == 4'hA);
    upd_dr_n += int'(updateDR);
    upd_ir_n += int'(updateIR);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int d0, i0, n;
    logic [3:0] e;
    #3 trst = 1'b0;
    #1;
    chk("rst_state", {28'd0, state}, 32'hF);
    chk("rst_reset", reset, 0);
    chk("rst_select", select, 0);
    chk("rst_upd", {updateDR, updateIR}, 0);
    chk("rst_tdo_en", tdo_en, 0);
    chk("rst_clk", {clockDR, clockIR}, 0);
    @(negedge tck); #1 trst = 1'b1;
    step(0);
    // DR scan: capture edge + 31 stay-in-shift edges + the shift edge leaving ShDR = 33
    d0 = dr_edges; i0 = ir_edges; cap_dr_n = 0; upd_dr_n = 0;
    step(1); step(0); step(0);
    repeat (31) step(0);
    step(1); step(1);
    chk("dr_end_state", {28'd0, state}, 32'h5);
    step(0);
    chk("dr_edges", dr_edges - d0, 33);
    chk("dr_capture_n", cap_dr_n, 1);
    chk("dr_update_n", upd_dr_n, 1);
    chk("dr_no_ir_edges", ir_edges - i0, 0);
    step(1); step(0); step(0);
    for (int i = 0; i < 32; i++) begin
      id_rd[i] = id_sr[0];
      step(i == 31);
    end
    step(1); step(0);
    chk("idcode", id_rd, ID);
    chk("id_first_bit", id_rd[0], 1);
    d0 = dr_edges; i0 = ir_edges; upd_ir_n = 0;
    step(1); step(1);
    chk("select_in_selir", select, 1);
    step(0); step(0);
    repeat (2) step(0);
    step(1); step(1); step(0);
    chk("ir_edges", ir_edges - i0, 4);
    chk("ir_no_dr_edges", dr_edges - d0, 0);
    chk("ir_update_n", upd_ir_n, 1);
    step(1); step(0); step(0);
    chk("tdo_en_shift", tdo_en, 1);
    step(1);
    d0 = dr_edges; upd_dr_n = 0;
    repeat (3) step(0);
    step(1); step(0);
    chk("pause_edges", dr_edges - d0, 0);
    chk("pause_no_update", upd_dr_n, 0);
    chk("tdo_en_resume", tdo_en, 1);
    tms = 1'b0;
    exp_q.push_back(4'h2);
    @(posedge tck); #1;
    e = exp_q.pop_front();
    chk("pre_rst_state", {28'd0, state}, {28'd0, e});
    chk("pre_rst_clockDR", clockDR, 1);
    #1 trst = 1'b0;
    #1;
    chk("async_state", {28'd0, state}, 32'hF);
    chk("async_clockDR", clockDR, 0);
    chk("async_strobes", {shiftDR, captureDR, tdo_en, updateDR, select, reset}, 0);
    @(negedge tck); #1;
    chk("async_no_update", updateDR, 0);
    trst = 1'b1;
    cur = 4'hF;
    step(0);
    for (int s = 0; s < 16; s++) begin
      repeat (5) step(1);
      n = 0;
      while (cur != 4'(s) && n < 400) begin
        step(1'($urandom_range(0, 1)));
        n++;
      end
      chk("walk_reach", {28'd0, state}, s);
      repeat (5) step(1);
      chk("tms5_to_tlr", {28'd0, state}, 32'hF);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
